// File: rtl/iob_gpio_sensor_sched_pkg.sv
// Shared types and defaults for the GPIO sensor measurement scheduler.
package iob_gpio_sensor_sched_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned STATE_W   = 2;

  // Scheduler FSM encoding; output decode depends on these exact values.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/iob_gpio_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by a registered
// rising-edge detector; the pulse appears 3 clocks after the pin edge.
module iob_gpio_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;

  // Metastability filter, history flop and one-cycle rise pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/iob_gpio_sensor_sched.sv
// Periodic measurement scheduler: every cfg_period cycles clears and enables
// the sensor capture core, times the delay to the first sensor rising edge
// (bounded by cfg_window) and holds the result in a valid/ack register.
module iob_gpio_sensor_sched
  import iob_gpio_sensor_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic             sensor_in,
  output logic             core_rst,
  output logic             core_enable,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_timeout,
  input  logic             meas_ack,
  output logic             overrun,
  input  logic             overrun_clr
);

  state_e           r_state;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_cap_count;
  logic             r_cap_to;
  logic             r_meas_valid;
  logic [CNT_W-1:0] r_meas_count;
  logic             r_meas_timeout;
  logic             r_overrun;

  logic             w_sens_rise;
  logic             w_period_run;
  logic             w_start;
  logic             w_push;
  logic             w_skip;
  logic             w_drop;

  iob_gpio_sync_edge u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (sensor_in),
    .o_rise  (w_sens_rise)
  );

  assign w_period_run = cfg_en && (cfg_period != '0);
  assign w_start      = w_period_run && (r_pcnt == (cfg_period - CNT_W'(1)));
  // An abort during DONE suppresses the push.
  assign w_push       = (r_state == ST_DONE) && cfg_en;
  assign w_skip       = w_start && (r_state != ST_IDLE);
  assign w_drop       = w_push && r_meas_valid && !meas_ack;

  // Period counter: free-runs modulo cfg_period while enabled, else held at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
    end else if (!w_period_run || w_start) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + CNT_W'(1);
    end
  end

  // Measurement FSM with wait counter and capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= '0;
      r_cap_count <= '0;
      r_cap_to    <= 1'b0;
    end else if (!cfg_en) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_wcnt  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Edge wins over a coincident timeout.
          if (w_sens_rise) begin
            r_cap_count <= r_wcnt;
            r_cap_to    <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_wcnt == cfg_window) begin
            r_cap_count <= cfg_window;
            r_cap_to    <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_wcnt <= r_wcnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Result register: load when empty or being acked in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meas_valid   <= 1'b0;
      r_meas_count   <= '0;
      r_meas_timeout <= 1'b0;
    end else if (w_push && (!r_meas_valid || meas_ack)) begin
      r_meas_valid   <= 1'b1;
      r_meas_count   <= r_cap_count;
      r_meas_timeout <= r_cap_to;
    end else if (meas_ack && r_meas_valid) begin
      r_meas_valid <= 1'b0;
    end
  end

  // Sticky overrun: a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_skip || w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign core_rst     = (r_state == ST_CLEAR);
  assign core_enable  = (r_state == ST_WAIT);
  assign busy         = (r_state != ST_IDLE);
  assign meas_valid   = r_meas_valid;
  assign meas_count   = r_meas_count;
  assign meas_timeout = r_meas_timeout;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_iob_gpio_sensor_sched.sv
// Bench for iob_gpio_sensor_sched: vector table of single measurements with a
// result scoreboard, plus sequences for overrun, abort and async reset.
module tb_iob_gpio_sensor_sched;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_window;
  logic             sensor_in;
  logic             core_rst;
  logic             core_enable;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_count;
  logic             meas_timeout;
  logic             meas_ack;
  logic             overrun;
  logic             overrun_clr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int period;
    int window;
    int rise_k;     // WAIT cycle index carrying sens_rise, -1 = none
    int exp_count;
    int exp_to;
  } vec_t;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             to;
    int               at;   // negedge index (from enable) where valid shows
  } sb_t;

  vec_t vecs[9];
  sb_t  sb[$];

  iob_gpio_sensor_sched #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_en       (cfg_en),
    .cfg_period   (cfg_period),
    .cfg_window   (cfg_window),
    .sensor_in    (sensor_in),
    .core_rst     (core_rst),
    .core_enable  (core_enable),
    .busy         (busy),
    .meas_valid   (meas_valid),
    .meas_count   (meas_count),
    .meas_timeout (meas_timeout),
    .meas_ack     (meas_ack),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One measurement from enable to acked result.
  task automatic run_vec(input vec_t v);
    sb_t e;
    int  exp_at;
    bit  got;
    exp_at = v.period + 3 + ((v.rise_k >= 0) ? v.rise_k : v.window);
    e.cnt = 16'(v.exp_count);
    e.to  = (v.exp_to != 0);
    e.at  = exp_at;
    sb.push_back(e);
    cfg_period = 16'(v.period);
    cfg_window = 16'(v.window);
    cfg_en     = 1'b1;
    got        = 1'b0;
    for (int n = 1; n <= exp_at + 10 && !got; n++) begin
      tick();
      if (v.rise_k >= 0 && n == v.period - 2 + v.rise_k) sensor_in = 1'b1;
      if (n == v.period - 1) check("pre_start_core_rst", 32'(core_rst), 0);
      if (n == v.period)     check("start_to_core_rst", 32'(core_rst), 1);
      if (n == v.period + 1) check("wait_rst_en_busy", 32'({core_rst, core_enable, busy}), 3);
      if (meas_valid) begin
        got = 1'b1;
        e = sb.pop_front();
        check("meas_count", 32'(meas_count), 32'(e.cnt));
        check("meas_timeout", 32'(meas_timeout), 32'(e.to));
        check("result_latency", 32'(n), 32'(e.at));
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL result_missing: got no meas_valid expected by cycle %0d", exp_at);
      void'(sb.pop_front());
    end
    cfg_en   = 1'b0;
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    check("ack_clears_valid", 32'(meas_valid), 0);
    sensor_in = 1'b0;
    ticks(5);
  endtask

  initial begin
    vecs[0] = '{period: 20, window: 8,  rise_k: 3,  exp_count: 3, exp_to: 0};
    vecs[1] = '{period: 20, window: 8,  rise_k: -1, exp_count: 8, exp_to: 1};
    vecs[2] = '{period: 20, window: 0,  rise_k: -1, exp_count: 0, exp_to: 1};
    vecs[3] = '{period: 20, window: 8,  rise_k: 0,  exp_count: 0, exp_to: 0};
    vecs[4] = '{period: 20, window: 5,  rise_k: 5,  exp_count: 5, exp_to: 0};
    vecs[5] = '{period: 20, window: 12, rise_k: 7,  exp_count: 7, exp_to: 0};
    vecs[6] = '{period: 7,  window: 2,  rise_k: -1, exp_count: 2, exp_to: 1};
    vecs[7] = '{period: 7,  window: 3,  rise_k: 1,  exp_count: 1, exp_to: 0};
    vecs[8] = '{period: 20, window: 0,  rise_k: 0,  exp_count: 0, exp_to: 0};

    // Reset with the pin high: everything quiet.
    rst = 1'b0; cfg_en = 1'b0; cfg_period = '0; cfg_window = '0;
    sensor_in = 1'b1; meas_ack = 1'b0; overrun_clr = 1'b0;
    ticks(2);
    check("reset_flags", 32'({core_rst, core_enable, busy, meas_valid, meas_timeout, overrun}), 0);
    check("reset_count", 32'(meas_count), 0);
    rst = 1'b1;
    cfg_period = 16'd3;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (core_rst || busy) seen++;
      end
      check("disabled_no_activity", 32'(seen), 0);
    end
    sensor_in = 1'b0;
    ticks(5);

    // Table-driven single measurements.
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    check("no_overrun_after_table", 32'(overrun), 0);

    // Drop on full register; set beats same-cycle clear; clear works alone.
    cfg_period = 16'd20; cfg_window = 16'd2; cfg_en = 1'b1;
    ticks(25);
    check("first_valid", 32'(meas_valid), 1);
    check("first_count", 32'(meas_count), 2);
    cfg_window = 16'd3;
    ticks(20);
    check("overrun_before_drop", 32'(overrun), 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_set_beats_clr", 32'(overrun), 1);
    check("retained_count", 32'(meas_count), 2);
    check("retained_timeout", 32'(meas_timeout), 1);
    check("retained_valid", 32'(meas_valid), 1);
    cfg_en = 1'b0; overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_clr", 32'(overrun), 0);
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    check("ack_after_drop", 32'(meas_valid), 0);

    // Push and ack in the same cycle: new result loads, no overrun.
    cfg_window = 16'd2; cfg_en = 1'b1;
    ticks(25);
    check("pa_first_count", 32'(meas_count), 2);
    cfg_window = 16'd4;
    ticks(21);
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    check("pa_valid", 32'(meas_valid), 1);
    check("pa_count", 32'(meas_count), 4);
    check("pa_timeout", 32'(meas_timeout), 1);
    check("pa_no_overrun", 32'(overrun), 0);
    cfg_en = 1'b0; meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    ticks(3);

    // Short period: start during WAIT is skipped; abort mid-WAIT.
    cfg_period = 16'd4; cfg_window = 16'd10; cfg_en = 1'b1;
    ticks(4);
    check("p4_core_rst", 32'(core_rst), 1);
    ticks(3);
    check("p4_no_overrun_yet", 32'(overrun), 0);
    tick();
    check("p4_skip_overrun", 32'(overrun), 1);
    check("p4_busy", 32'(core_enable), 1);
    tick();
    cfg_en = 1'b0;
    tick();
    check("abort_idle", 32'({busy, core_enable}), 0);
    ticks(20);
    check("abort_no_result", 32'(meas_valid), 0);

    // Re-enable: period counter restarts from 0 after abort.
    cfg_period = 16'd20; cfg_window = 16'd10; cfg_en = 1'b1;
    ticks(19);
    check("reen_pre_core_rst", 32'(core_rst), 0);
    tick();
    check("reen_core_rst", 32'(core_rst), 1);
    ticks(3);
    check("mid_wait_busy", 32'(core_enable), 1);

    // Asynchronous reset between edges, mid-WAIT.
    #2 rst = 1'b0;
    #1;
    check("async_rst_flags", 32'({core_rst, core_enable, busy, meas_valid, meas_timeout, overrun}), 0);
    check("async_rst_count", 32'(meas_count), 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 0);
    ticks(18);
    check("post_rst_pre_start", 32'(core_rst), 0);
    tick();
    check("post_rst_pcnt_restart", 32'(core_rst), 1);
    cfg_en = 1'b0;
    ticks(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
